// File: rtl/pt_pkg.sv
// pt_pkg: shared definitions for the page table unit.
//   - request op encodings
//   - controller FSM state type
//   - entry field offsets; each entry is packed as {valid, dirty, ref, ppn}
//     with ppn at the LSBs, so the upper offsets depend on the PPN width.
package pt_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP    = 2'd0,
        OP_WRITEBACK = 2'd1,
        OP_MAP       = 2'd2,
        OP_UNMAP     = 2'd3
    } pt_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } pt_state_e;

    localparam int ENT_PPN_LSB = 0;

    function automatic int ent_ref_bit(input int ppn_w);
        return ppn_w;
    endfunction

    function automatic int ent_dirty_bit(input int ppn_w);
        return ppn_w + 1;
    endfunction

    function automatic int ent_valid_bit(input int ppn_w);
        return ppn_w + 2;
    endfunction

    function automatic int ent_w(input int ppn_w);
        return ppn_w + 3;
    endfunction

endpackage

// File: rtl/pt_entry_array.sv
// pt_entry_array: page table storage plus the per-op entry update rule.
//   clk, rst_n     : clock, async active-low reset (clears every entry)
//   op, vpn        : operation and target entry (shared read/write address)
//   ppn, dirty     : request payload for WRITEBACK / MAP
//   wr_en          : commit the updated entry this cycle
//   rsp_*          : response fields derived from the entry for this op
//   lookup_fault   : this op is a LOOKUP of an invalid entry (counted upstream)
module pt_entry_array
    import pt_pkg::*;
#(
    parameter int VPN_W = 6,
    parameter int PPN_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  pt_op_e           op,
    input  logic [VPN_W-1:0] vpn,
    input  logic [PPN_W-1:0] ppn,
    input  logic             dirty,
    input  logic             wr_en,
    output logic [PPN_W-1:0] rsp_ppn,
    output logic             rsp_fault,
    output logic             rsp_ref,
    output logic             rsp_dirty,
    output logic             lookup_fault
);

    localparam int DEPTH   = 2 ** VPN_W;
    localparam int EW      = ent_w(PPN_W);
    localparam int REF_B   = ent_ref_bit(PPN_W);
    localparam int DIRTY_B = ent_dirty_bit(PPN_W);
    localparam int VALID_B = ent_valid_bit(PPN_W);

    logic [EW-1:0] ent_q [DEPTH];
    logic [EW-1:0] cur;
    logic [EW-1:0] nxt;

    // Read port: combinational, addressed by the latched request vpn.
    assign cur = ent_q[vpn];

    always_comb begin
        nxt          = cur;
        rsp_fault    = 1'b0;
        lookup_fault = 1'b0;
        case (op)
            OP_LOOKUP: begin
                if (cur[VALID_B]) begin
                    nxt[REF_B] = 1'b1;
                end else begin
                    // Invalid entry: report, leave the entry untouched.
                    rsp_fault    = 1'b1;
                    lookup_fault = 1'b1;
                end
            end
            OP_WRITEBACK: begin
                nxt[ENT_PPN_LSB +: PPN_W] = ppn;
                nxt[REF_B]                = 1'b1;
                nxt[DIRTY_B]              = cur[DIRTY_B] | dirty;
                // Fields still update on an unmapped entry; only flagged.
                rsp_fault                 = ~cur[VALID_B];
            end
            OP_MAP: begin
                nxt[VALID_B]              = 1'b1;
                nxt[ENT_PPN_LSB +: PPN_W] = ppn;
                nxt[REF_B]                = 1'b0;
                nxt[DIRTY_B]              = 1'b0;
            end
            OP_UNMAP: begin
                nxt[VALID_B] = 1'b0;
                nxt[REF_B]   = 1'b0;
                nxt[DIRTY_B] = 1'b0;
            end
            default: ;
        endcase
    end

    assign rsp_ppn   = nxt[ENT_PPN_LSB +: PPN_W];
    assign rsp_ref   = nxt[REF_B];
    // UNMAP returns the pre-clear dirty bit so the requester knows to write back.
    assign rsp_dirty = (op == OP_UNMAP) ? cur[DIRTY_B] : nxt[DIRTY_B];

    // Write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else if (wr_en) begin
            ent_q[vpn] <= nxt;
        end
    end

endmodule

// File: rtl/page_table_unit.sv
// page_table_unit: single-outstanding page table with fixed access latency.
//   clk, rst_n            : clock, async active-low reset
//   req_valid/req_ready   : request handshake (ready only when idle)
//   req_op/vpn/ppn/dirty  : LOOKUP / WRITEBACK / MAP / UNMAP and payload
//   resp_valid/resp_ready : response handshake; fields held until accepted
//   resp_ppn/fault/ref/dirty : entry state after the op (UNMAP: old dirty)
//   fault_count           : saturating count of faulting LOOKUPs
module page_table_unit
    import pt_pkg::*;
#(
    parameter int VPN_W   = 6,
    parameter int PPN_W   = 2,
    parameter int LATENCY = 2,
    parameter int FCNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [VPN_W-1:0]  req_vpn,
    input  logic [PPN_W-1:0]  req_ppn,
    input  logic              req_dirty,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [PPN_W-1:0]  resp_ppn,
    output logic              resp_fault,
    output logic              resp_ref,
    output logic              resp_dirty,
    output logic [FCNT_W-1:0] fault_count
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("page_table_unit: LATENCY must be 1..15");
    end

    pt_state_e        state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             accept, upd;

    pt_op_e           op_q;
    logic [VPN_W-1:0] vpn_q;
    logic [PPN_W-1:0] ppn_q;
    logic             dirty_q;

    logic [PPN_W-1:0] a_ppn;
    logic             a_fault, a_ref, a_dirty, a_lookup_fault;

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        upd     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    upd     = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch, response registers and fault counter. The response is
    // captured on the same edge the table is written, so the entry array
    // sees a stable address for the whole BUSY window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= OP_LOOKUP;
            vpn_q       <= '0;
            ppn_q       <= '0;
            dirty_q     <= 1'b0;
            resp_ppn    <= '0;
            resp_fault  <= 1'b0;
            resp_ref    <= 1'b0;
            resp_dirty  <= 1'b0;
            fault_count <= '0;
        end else begin
            if (accept) begin
                op_q    <= pt_op_e'(req_op);
                vpn_q   <= req_vpn;
                ppn_q   <= req_ppn;
                dirty_q <= req_dirty;
            end
            if (upd) begin
                resp_ppn   <= a_ppn;
                resp_fault <= a_fault;
                resp_ref   <= a_ref;
                resp_dirty <= a_dirty;
                if (a_lookup_fault && (fault_count != '1))
                    fault_count <= fault_count + 1'b1;
            end
        end
    end

    pt_entry_array #(
        .VPN_W (VPN_W),
        .PPN_W (PPN_W)
    ) u_array (
        .clk          (clk),
        .rst_n        (rst_n),
        .op           (op_q),
        .vpn          (vpn_q),
        .ppn          (ppn_q),
        .dirty        (dirty_q),
        .wr_en        (upd),
        .rsp_ppn      (a_ppn),
        .rsp_fault    (a_fault),
        .rsp_ref      (a_ref),
        .rsp_dirty    (a_dirty),
        .lookup_fault (a_lookup_fault)
    );

endmodule

// File: tb/tb_page_table_unit.sv
// Scoreboard bench: the driver pushes hand-computed expected responses on
// acceptance; a negedge monitor compares every cycle a response is presented
// and pops on handshake. A second instance with FCNT_W=2 shares all inputs
// and exercises fault counter saturation.
module tb_page_table_unit;

    localparam int VPN_W = 6;
    localparam int PPN_W = 2;
    localparam int LAT   = 2;

    localparam logic [1:0] LK = 2'd0, WB = 2'd1, MP = 2'd2, UM = 2'd3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = 2'd0;
    logic [VPN_W-1:0] req_vpn = '0;
    logic [PPN_W-1:0] req_ppn = '0;
    logic             req_dirty = 1'b0;
    logic             resp_valid;
    logic             resp_ready = 1'b1;
    logic [PPN_W-1:0] resp_ppn;
    logic             resp_fault, resp_ref, resp_dirty;
    logic [7:0]       fault_count;

    logic             s_req_ready, s_resp_valid, s_resp_fault, s_resp_ref, s_resp_dirty;
    logic [PPN_W-1:0] s_resp_ppn;
    logic [1:0]       s_fault_count;

    always #5 clk = ~clk;

    page_table_unit #(.VPN_W(VPN_W), .PPN_W(PPN_W), .LATENCY(LAT), .FCNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_vpn(req_vpn), .req_ppn(req_ppn), .req_dirty(req_dirty),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_ppn(resp_ppn),
        .resp_fault(resp_fault), .resp_ref(resp_ref), .resp_dirty(resp_dirty),
        .fault_count(fault_count)
    );

    page_table_unit #(.VPN_W(VPN_W), .PPN_W(PPN_W), .LATENCY(LAT), .FCNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(s_req_ready), .req_op(req_op),
        .req_vpn(req_vpn), .req_ppn(req_ppn), .req_dirty(req_dirty),
        .resp_valid(s_resp_valid), .resp_ready(resp_ready), .resp_ppn(s_resp_ppn),
        .resp_fault(s_resp_fault), .resp_ref(s_resp_ref), .resp_dirty(s_resp_dirty),
        .fault_count(s_fault_count)
    );

    typedef struct {
        logic [1:0] ppn;
        logic       fault;
        logic       rf;
        logic       dirty;
        int         fc;
        int         sat;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   hs = 0;
    bit   seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare on every presented cycle, so a stalled response is
    // also checked for stability.
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb[0];
                if (!seen) begin
                    chk("latency", 32'(cyc - e.acc), 32'(LAT));
                    seen = 1'b1;
                end
                chk("resp_ppn", 32'(resp_ppn), 32'(e.ppn));
                chk("resp_fault", 32'(resp_fault), 32'(e.fault));
                chk("resp_ref", 32'(resp_ref), 32'(e.rf));
                chk("resp_dirty", 32'(resp_dirty), 32'(e.dirty));
                chk("fault_count", 32'(fault_count), 32'(e.fc));
                chk("sat_fault_count", 32'(s_fault_count), 32'(e.sat));
                chk("req_ready_in_resp", 32'(req_ready), 32'd0);
                if (resp_ready) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input int vpn, input int ppn, input bit d,
                        input bit push, input logic [1:0] eppn, input bit ef, input bit er,
                        input bit ed, input int efc, input int esat);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_vpn   = VPN_W'(vpn);
        req_ppn   = PPN_W'(ppn);
        req_dirty = d;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        last_acc = cyc + 1;
        if (push) sb.push_back('{eppn, ef, er, ed, efc, esat, cyc + 1});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_idle_reset(input string tag);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_ppn"}, 32'(resp_ppn), 32'd0);
        chk({tag, "_resp_flags"}, 32'({resp_fault, resp_ref, resp_dirty}), 32'd0);
        chk({tag, "_fault_count"}, 32'(fault_count), 32'd0);
        chk({tag, "_sat_fault_count"}, 32'(s_fault_count), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_idle_reset("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_ready_after_reset", 32'(req_ready), 32'd1);

        //   op  vpn ppn d  push  eppn f r d  fc sat
        send(LK,  4, 0, 0, 1,    0, 1, 0, 0, 1, 1);   // unmapped -> fault
        send(MP,  4, 2, 0, 1,    2, 0, 0, 0, 1, 1);
        send(LK,  4, 0, 0, 1,    2, 0, 1, 0, 1, 1);
        send(MP,  7, 1, 0, 1,    1, 0, 0, 0, 1, 1);
        send(WB,  7, 3, 1, 1,    3, 0, 1, 1, 1, 1);
        send(UM,  7, 0, 0, 1,    3, 0, 0, 1, 1, 1);   // old dirty returned
        send(LK,  7, 0, 0, 1,    3, 1, 0, 0, 2, 2);
        send(LK,  4, 0, 0, 1,    2, 0, 1, 0, 2, 2);   // vpn 4 untouched
        send(WB,  9, 1, 0, 1,    1, 1, 1, 0, 2, 2);   // invalid: update, flag, no count
        send(LK,  9, 0, 0, 1,    1, 1, 1, 0, 3, 3);
        send(MP, 63, 3, 0, 1,    3, 0, 0, 0, 3, 3);
        send(LK, 63, 0, 0, 1,    3, 0, 1, 0, 3, 3);
        send(LK,  0, 0, 0, 1,    0, 1, 0, 0, 4, 3);   // narrow counter saturates
        send(MP,  0, 1, 0, 1,    1, 0, 0, 0, 4, 3);
        send(LK, 63, 0, 0, 1,    3, 0, 1, 0, 4, 3);   // no aliasing 0 vs 63
        send(LK,  1, 0, 0, 1,    0, 1, 0, 0, 5, 3);
        drain();

        // Back-pressure with a second request pending.
        resp_ready = 1'b0;
        send(MP, 5, 2, 0, 1, 2, 0, 0, 0, 5, 3);
        fork
            send(LK, 5, 0, 0, 1, 2, 0, 1, 0, 5, 3);
            begin
                int n = 0;
                while (!resp_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                repeat (5) @(negedge clk);
                chk("stall_resp_valid", 32'(resp_valid), 32'd1);
                chk("stall_req_ready", 32'(req_ready), 32'd0);
                @(posedge clk);
                #1;
                resp_ready = 1'b1;
                hs = cyc + 1;
            end
        join
        chk("accept_after_release", 32'(last_acc), 32'(hs + 1));
        drain();

        // Reset while BUSY on MAP 63: no response, table cleared.
        send(MP, 63, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_resp", 32'(resp_valid), 32'd0);
        end
        check_idle_reset("after_abort");
        send(LK, 63, 0, 0, 1, 0, 1, 0, 0, 1, 1);
        send(LK,  4, 0, 0, 1, 0, 1, 0, 0, 2, 2);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
